// File: rtl/rf3_bus_arbiter.sv
// rf3_bus_arbiter: round-robin two-master arbiter in front of a 3-entry register file (0x0120..0x0122).
// Ports: clk, reset_n (sync, active-low); per master N: mN_req/mN_wr/mN_addr/mN_wdata in,
// mN_grant/mN_ack/mN_err out; rdata out; register-file side rf_we/rf_waddr/rf_raddr/rf_wdata out, rf_rdata in.
// Option: define RF3_ARB_ERR_EN to flag invalid-address accesses with mN_err alongside mN_ack.
module rf3_bus_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [63:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m1_wdata,
  output logic        m0_grant,
  output logic        m0_ack,
  output logic        m0_err,
  output logic        m1_grant,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [63:0] rdata,
  output logic        rf_we,
  output logic [15:0] rf_waddr,
  output logic [15:0] rf_raddr,
  output logic [63:0] rf_wdata,
  input  logic [63:0] rf_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state, state_nxt;
  logic        owner, last, lat_wr, addr_ok, pick, any_req, bad;
  logic [15:0] lat_addr;
  logic [63:0] lat_wdata;
  assign any_req  = m0_req | m1_req;
  // on a tie the master not served last wins; otherwise the lone requester
  assign pick     = (m0_req & m1_req) ? ~last : m1_req;
  assign addr_ok  = lat_addr inside {16'h0120, 16'h0121, 16'h0122};
  assign rf_waddr = lat_addr;
  assign rf_raddr = lat_addr;
  assign rf_wdata = lat_wdata;
`ifdef RF3_ARB_ERR_EN
  assign bad = ~addr_ok;
`else
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // strobes are gated by reset_n so an aborted access never writes or acks
  always_comb begin
    state_nxt = state == IDLE ? (any_req ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
    m0_grant  = reset_n && state == ACCESS && !owner;
    m1_grant  = reset_n && state == ACCESS && owner;
    m0_ack    = reset_n && state == RESP && !owner;
    m1_ack    = reset_n && state == RESP && owner;
    m0_err    = m0_ack && bad;
    m1_err    = m1_ack && bad;
    rf_we     = reset_n && state == ACCESS && lat_wr && addr_ok;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= pick;
        lat_wr    <= pick ? m1_wr : m0_wr;
        lat_addr  <= pick ? m1_addr : m0_addr;
        lat_wdata <= pick ? m1_wdata : m0_wdata;
      end
      if (state == ACCESS) rdata <= (!lat_wr && addr_ok) ? rf_rdata : '0;
      if (state == RESP) last <= owner;
    end
endmodule

// File: tb/tb_rf3_bus_arbiter.sv
// tb_rf3_bus_arbiter: directed checks of rf3_bus_arbiter against hand-computed values.
module tb_rf3_bus_arbiter;
`ifdef RF3_ARB_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [15:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_grant, m0_ack, m0_err, m1_grant, m1_ack, m1_err;
  logic [63:0] rdata, rf_wdata, rf_rdata;
  logic        rf_we;
  logic [15:0] rf_waddr, rf_raddr;
  logic [63:0] regs [0:3] = '{64'h1111, 64'h0, 64'h3333, 64'h0};
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (rf_we) regs[rf_waddr[1:0]] <= rf_wdata;
  assign rf_rdata = regs[rf_raddr[1:0]];
  rf3_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_grant(m0_grant), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_grant(m1_grant), .m1_ack(m1_ack), .m1_err(m1_err),
    .rdata(rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_raddr(rf_raddr),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    reset_n = 1'b0;
    {m0_req, m0_wr, m1_req, m1_wr} = '0;
    {m0_addr, m1_addr} = '0;
    {m0_wdata, m1_wdata} = '0;
    tick;
    tick;
    check("rst_strobes", {m0_grant, m1_grant, m0_ack, m1_ack, m0_err, m1_err, rf_we}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    reset_n = 1'b1;
    tick;
    check("idle_no_req", {m0_grant, m1_grant, m0_ack, m1_ack}, 0);
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0121; m0_wdata = 64'hDEADBEEF_01234567;
    tick;
    m0_req = 1'b0; m0_addr = 16'h0122; m0_wdata = 64'h0;
    check("wr_grant", {m0_grant, m1_grant}, 2'b10);
    check("wr_we", rf_we, 1);
    check("wr_waddr_held", rf_waddr, 16'h0121);
    check("wr_wdata_held", rf_wdata, 64'hDEADBEEF_01234567);
    tick;
    check("wr_ack", {m0_ack, m1_ack, m0_err}, 3'b100);
    check("wr_resp_quiet", {rf_we, m0_grant}, 0);
    check("wr_landed", regs[1], 64'hDEADBEEF_01234567);
    tick;
    check("wr_ack_gone", m0_ack, 0);
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 16'h0121;
    tick;
    m1_req = 1'b0;
    check("rd_grant", {m0_grant, m1_grant, rf_we}, 3'b010);
    check("rd_raddr", rf_raddr, 16'h0121);
    tick;
    check("rd_ack", {m0_ack, m1_ack, m1_err}, 3'b010);
    check("rd_data", rdata, 64'hDEADBEEF_01234567);
    tick;
    check("rd_hold", rdata, 64'hDEADBEEF_01234567);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
    m0_addr = 16'h0120; m1_addr = 16'h0122;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("rr_grant", {m0_grant, m1_grant}, (i % 2) ? 2'b01 : 2'b10);
      tick;
      check("rr_ack", {m0_ack, m1_ack}, (i % 2) ? 2'b01 : 2'b10);
      check("rr_rdata", rdata, (i % 2) ? 64'h3333 : 64'h1111);
      tick;
      check("rr_idle", {m0_grant, m1_grant, m0_ack, m1_ack}, 0);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0123; m0_wdata = 64'hFFFF;
    tick;
    m0_req = 1'b0;
    check("bad_grant", {m0_grant, rf_we}, 2'b10);
    tick;
    check("bad_ack", {m0_ack, m0_err, m1_ack, m1_err}, {1'b1, EXP_ERR, 2'b00});
    check("bad_rdata", rdata, 0);
    check("bad_no_we", rf_we, 0);
    tick;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0120; m0_wdata = 64'hABCD;
    tick;
    m0_req = 1'b0;
    check("abort_we_pre", rf_we, 1);
    reset_n = 1'b0;
    #1;
    check("abort_gated", {rf_we, m0_grant}, 0);
    tick;
    check("abort_no_ack", {m0_ack, m1_ack}, 0);
    check("abort_no_write", regs[0], 64'h1111);
    check("abort_addr_clr", rf_waddr, 0);
    tick;
    reset_n = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_wr = 1'b0; m1_wr = 1'b0;
    tick;
    check("abort_tie_m0", {m0_grant, m1_grant}, 2'b10);
    tick;
    m0_req = 1'b0; m1_req = 1'b0;
    check("abort_tie_ack", {m0_ack, m1_ack}, 2'b10);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
